// File: rtl/ex4_sad_pkg.sv
// rtl/ex4_sad_pkg.sv - shared constants and stage record for the EX4 SAD reducer
//
// Purpose: widths, the best-SAD reset value and the S1 pipeline record used
// by ex4_sad_reduce and sad_adder4.
// Ports: none (package).
package ex4_sad_pkg;

    localparam int NUM_DIFF = 16;
    localparam int SAD_W    = 32;
    localparam logic [SAD_W-1:0] SAD_INIT = 32'hFFFF_FFFF;

    // S1 holds the four partial sums plus the candidate's control and coordinates.
    typedef struct packed {
        logic                        valid;
        logic                        start;
        logic                        last;
        logic [SAD_W-1:0]            x;
        logic [SAD_W-1:0]            y;
        logic [3:0][SAD_W-1:0]       part;
    } s1_t;

endpackage

// File: rtl/sad_adder4.sv
// rtl/sad_adder4.sv - sum of the low PIX_W bits of four difference inputs
//
// Purpose: one quarter of the 16-input SAD sum; upper input bits are ignored.
// Ports:
//   in_a..in_d  : SAD_W-bit absolute differences (only [PIX_W-1:0] used)
//   sum         : zero-extended unsigned sum of the four masked inputs
module sad_adder4
    import ex4_sad_pkg::*;
#(
    parameter int PIX_W = 8
)
(
    input  logic [SAD_W-1:0] in_a,
    input  logic [SAD_W-1:0] in_b,
    input  logic [SAD_W-1:0] in_c,
    input  logic [SAD_W-1:0] in_d,
    output logic [SAD_W-1:0] sum
);

    // Mask keeps only the pixel-difference bits; computed in 64 bits so that
    // PIX_W == 32 does not overflow the shift.
    localparam logic [63:0]      MASK64   = (64'd1 << PIX_W) - 64'd1;
    localparam logic [SAD_W-1:0] PIX_MASK = MASK64[SAD_W-1:0];

    assign sum = (in_a & PIX_MASK) + (in_b & PIX_MASK)
               + (in_c & PIX_MASK) + (in_d & PIX_MASK);

endmodule

// File: rtl/ex4_sad_reduce.sv
// rtl/ex4_sad_reduce.sv - two-stage SAD reduction with running best-match tracking
//
// Purpose: sums 16 absolute pixel differences per candidate and keeps the
// minimum SAD and its window coordinates across a search.
// Optional feature macro: EX4_SAD_TIE_LATEST_EN (equal SAD replaces best).
// Ports:
//   Clk, Reset          : rising-edge clock, asynchronous active-low reset
//   Flush               : kill all in-flight candidates, hold result
//   InValid/InStart/InLast : candidate strobe, first / last of search
//   In1..In16           : absolute differences, low PIX_W bits summed
//   CandX, CandY        : candidate window coordinates
//   SadOut, OutX, OutY  : best SAD so far and its coordinates
//   SadValid            : at least one candidate accumulated
//   Done                : one-cycle pulse after the last candidate settles
//   Busy                : a pipeline stage holds a valid candidate
module ex4_sad_reduce
    import ex4_sad_pkg::*;
#(
    parameter int PIX_W = 8
)
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Flush,
    input  logic             InValid,
    input  logic             InStart,
    input  logic             InLast,
    input  logic [SAD_W-1:0] In1,
    input  logic [SAD_W-1:0] In2,
    input  logic [SAD_W-1:0] In3,
    input  logic [SAD_W-1:0] In4,
    input  logic [SAD_W-1:0] In5,
    input  logic [SAD_W-1:0] In6,
    input  logic [SAD_W-1:0] In7,
    input  logic [SAD_W-1:0] In8,
    input  logic [SAD_W-1:0] In9,
    input  logic [SAD_W-1:0] In10,
    input  logic [SAD_W-1:0] In11,
    input  logic [SAD_W-1:0] In12,
    input  logic [SAD_W-1:0] In13,
    input  logic [SAD_W-1:0] In14,
    input  logic [SAD_W-1:0] In15,
    input  logic [SAD_W-1:0] In16,
    input  logic [SAD_W-1:0] CandX,
    input  logic [SAD_W-1:0] CandY,
    output logic [SAD_W-1:0] SadOut,
    output logic [SAD_W-1:0] OutX,
    output logic [SAD_W-1:0] OutY,
    output logic             SadValid,
    output logic             Done,
    output logic             Busy
);

    logic [SAD_W-1:0] part0, part1, part2, part3;

    sad_adder4 #(.PIX_W(PIX_W)) u_add0 (.in_a(In1),  .in_b(In2),  .in_c(In3),  .in_d(In4),  .sum(part0));
    sad_adder4 #(.PIX_W(PIX_W)) u_add1 (.in_a(In5),  .in_b(In6),  .in_c(In7),  .in_d(In8),  .sum(part1));
    sad_adder4 #(.PIX_W(PIX_W)) u_add2 (.in_a(In9),  .in_b(In10), .in_c(In11), .in_d(In12), .sum(part2));
    sad_adder4 #(.PIX_W(PIX_W)) u_add3 (.in_a(In13), .in_b(In14), .in_c(In15), .in_d(In16), .sum(part3));

    s1_t              s1_d, s1_q;
    logic             s2_valid_d, s2_valid_q;
    logic             s2_last_d, s2_last_q;
    logic [SAD_W-1:0] best_d, best_q;
    logic [SAD_W-1:0] best_x_d, best_x_q;
    logic [SAD_W-1:0] best_y_d, best_y_q;
    logic             sad_valid_d, sad_valid_q;
    logic             done_d, done_q;

    logic [SAD_W-1:0] total;
    logic             better;
    logic             s2_fire;
    logic             take;

    // S1 capture: a flush in the same cycle drops the incoming candidate.
    always_comb begin
        s1_d       = '0;
        s1_d.valid = InValid & ~Flush;
        s1_d.start = InStart;
        s1_d.last  = InLast;
        s1_d.x     = CandX;
        s1_d.y     = CandY;
        s1_d.part  = {part3, part2, part1, part0};
    end

    // S2: final add and compare against best, committed at the S2 edge.
    always_comb begin
        total = s1_q.part[0] + s1_q.part[1] + s1_q.part[2] + s1_q.part[3];
`ifdef EX4_SAD_TIE_LATEST_EN
        better = (total <= best_q);
`else
        better = (total < best_q);
`endif
        s2_fire = s1_q.valid & ~Flush;
        // A start candidate overwrites whatever the previous search left.
        take    = s2_fire & (s1_q.start | better);

        best_d      = take ? total    : best_q;
        best_x_d    = take ? s1_q.x   : best_x_q;
        best_y_d    = take ? s1_q.y   : best_y_q;
        sad_valid_d = sad_valid_q | s2_fire;

        s2_valid_d  = s2_fire;
        s2_last_d   = s1_q.last;

        // Done trails the S2 edge by one cycle; a flush here suppresses it.
        done_d      = s2_valid_q & s2_last_q & ~Flush;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            s1_q        <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            best_q      <= SAD_INIT;
            best_x_q    <= '0;
            best_y_q    <= '0;
            sad_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            best_q      <= best_d;
            best_x_q    <= best_x_d;
            best_y_q    <= best_y_d;
            sad_valid_q <= sad_valid_d;
            done_q      <= done_d;
        end
    end

    assign SadOut   = best_q;
    assign OutX     = best_x_q;
    assign OutY     = best_y_q;
    assign SadValid = sad_valid_q;
    assign Done     = done_q;
    assign Busy     = s1_q.valid | s2_valid_q;

endmodule
